// File: rtl/axis_frame_gen.sv
// Synthetic Ethernet frame source for the LMAC TX AXI-Stream port.
// Header template + 16-bit sequence number + incrementing byte payload, with programmable length/count/gap.
module axis_frame_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] frame_len,
    input  logic [15:0] num_frames,
    input  logic [7:0]  ifg_cycles,
    output logic        s_axis_tvalid,
    input  logic        s_axis_tready,
    output logic [63:0] s_axis_tdata,
    output logic [7:0]  s_axis_tkeep,
    output logic        s_axis_tlast,
    output logic        busy,
    output logic        done,
    output logic [15:0] frames_sent,
    output logic [2:0]  dbg_state
);

    // Handshake: a beat transfers on any rising edge where tvalid and tready are both high;
    // tdata/tkeep/tlast hold steady while tvalid is high and tready is low.
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, IFG} state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_len;
    logic [15:0] r_num;
    logic [7:0]  r_ifg;
    logic [7:0]  r_beat, w_beat_nxt;
    logic [15:0] r_seq, w_seq_nxt;
    logic [15:0] r_frames, w_frames_nxt;
    logic [7:0]  r_ifg_cnt, w_ifg_cnt_nxt;
    logic        r_stop_pend;
    logic        r_tvalid, w_valid_nxt;
    logic [63:0] r_tdata;
    logic [7:0]  r_tkeep;
    logic        r_tlast;
    logic        r_busy;
    logic        r_done, w_done_nxt;
    logic        w_start;
    logic        w_load;
    logic        w_hs;
    logic        w_end_run;
    logic [10:0] w_len_clamp;
    logic [10:0] w_len_nxt;
    logic [10:0] w_len_p7;
    logic [7:0]  w_last_idx;
    logic [127:0] w_hdr;
    logic [10:0] w_off [8];
    logic [63:0] w_beat_data;
    logic [7:0]  w_beat_keep;
    logic        w_beat_last;

    assign w_hs        = r_tvalid & s_axis_tready;
    assign w_len_clamp = (frame_len < 11'd60)   ? 11'd60 :
                         (frame_len > 11'd1514) ? 11'd1514 : frame_len;
    assign w_len_nxt   = w_start ? w_len_clamp : r_len;
    assign w_end_run   = r_stop_pend | stop |
                         ((r_num != 16'd0) && ((r_frames + 16'd1) == r_num));

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_seq_nxt     = r_seq;
        w_frames_nxt  = r_frames;
        w_ifg_cnt_nxt = r_ifg_cnt;
        w_valid_nxt   = r_tvalid;
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;
        w_start       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start      = 1'b1;
                    w_state_nxt  = HDR0;
                    w_beat_nxt   = 8'd0;
                    w_seq_nxt    = 16'd0;
                    w_frames_nxt = 16'd0;
                    w_valid_nxt  = 1'b1;
                    w_load       = 1'b1;
                end
            end
            HDR0, HDR1, PAYLOAD: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_frames_nxt = r_frames + 16'd1;
                        w_seq_nxt    = r_seq + 16'd1;
                        if (w_end_run) begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else if (r_ifg == 8'd0) begin
                            w_state_nxt = HDR0;
                            w_beat_nxt  = 8'd0;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt   = IFG;
                            w_ifg_cnt_nxt = r_ifg;
                            w_valid_nxt   = 1'b0;
                        end
                    end else begin
                        w_beat_nxt  = r_beat + 8'd1;
                        w_state_nxt = (r_beat == 8'd0) ? HDR1 : PAYLOAD;
                        w_load      = 1'b1;
                    end
                end
            end
            IFG: begin
                if (r_stop_pend | stop) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_ifg_cnt == 8'd1) begin
                    w_state_nxt = HDR0;
                    w_beat_nxt  = 8'd0;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt - 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Contents of the beat about to be presented; byte 0 of the header sits in the MSBs of w_hdr.
    always_comb begin
        w_hdr       = {DST_MAC, SRC_MAC, ETHERTYPE, w_seq_nxt};
        w_len_p7    = w_len_nxt + 11'd7;
        w_last_idx  = w_len_p7[10:3] - 8'd1;
        w_beat_last = (w_beat_nxt == w_last_idx);
        w_beat_data = 64'd0;
        w_beat_keep = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_off[i] = {w_beat_nxt, 3'b000} + 11'(i);
            w_beat_keep[i] = (w_off[i] < w_len_nxt);
            if (w_off[i] < 11'd16)
                w_beat_data[8*i +: 8] = w_hdr[(7'd120 - {w_off[i][3:0], 3'b000}) +: 8];
            else if (w_off[i] < w_len_nxt)
                w_beat_data[8*i +: 8] = w_off[i][7:0];
        end
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= 11'd60;
            r_num       <= 16'd0;
            r_ifg       <= 8'd0;
            r_beat      <= 8'd0;
            r_seq       <= 16'd0;
            r_frames    <= 16'd0;
            r_ifg_cnt   <= 8'd0;
            r_stop_pend <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tdata     <= 64'd0;
            r_tkeep     <= 8'd0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_seq     <= w_seq_nxt;
            r_frames  <= w_frames_nxt;
            r_ifg_cnt <= w_ifg_cnt_nxt;
            r_tvalid  <= w_valid_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
            if (w_start) begin
                r_len <= w_len_clamp;
                r_num <= num_frames;
                r_ifg <= ifg_cycles;
            end
            // A stop arriving together with start still lets the first frame go out.
            if (w_start)
                r_stop_pend <= stop;
            else if (w_state_nxt == IDLE)
                r_stop_pend <= 1'b0;
            else if (stop)
                r_stop_pend <= 1'b1;
            if (w_load) begin
                r_tdata <= w_beat_data;
                r_tkeep <= w_beat_keep;
                r_tlast <= w_beat_last;
            end else if (!w_valid_nxt) begin
                r_tdata <= 64'd0;
                r_tkeep <= 8'd0;
                r_tlast <= 1'b0;
            end
        end
    end

    assign s_axis_tvalid = r_tvalid;
    assign s_axis_tdata  = r_tdata;
    assign s_axis_tkeep  = r_tkeep;
    assign s_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign frames_sent   = r_frames;
    assign dbg_state     = r_state;

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Synthetic Ethernet frame source that drives the 64-bit TX AXI-Stream user port (s_axis_*) of the LMAC core on the DMA clock domain. It builds frames from a header template, a per-frame sequence number and an incrementing byte payload, with programmable length, count and inter-frame gap. It stands in for the DMA engine during bring-up and throughput testing.

## Interface
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC (wire byte 0 = DST_MAC[47:40])
- SRC_MAC, 48'h0002_0304_0506, source MAC (wire byte 6 = SRC_MAC[47:40])
- ETHERTYPE, 16'h88B5, EtherType placed at bytes 12-13
- dclk  in  1  DMA-side clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begins a run when idle, ignored when busy
- stop  in  1  pulse; finishes the current frame, then ends the run
- frame_len  in  11  frame bytes excluding FCS; sampled on start
- num_frames  in  16  frames per run; 0 = continuous until stop; sampled on start
- ifg_cycles  in  8  idle cycles between frames; sampled on start
- s_axis_tvalid  out  1  beat valid
- s_axis_tready  in  1  LMAC ready
- s_axis_tdata  out  64  beat data, byte k of the beat in [8k+7:8k]
- s_axis_tkeep  out  8  byte enables
- s_axis_tlast  out  1  last beat of frame
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when a run ends
- frames_sent  out  16  frames completed in the current or last run; wraps at 16'hFFFF

## Operation
- States: IDLE, HDR0, HDR1, PAYLOAD, IFG.
- On start in IDLE:
  - Latch parameters and clamp length: len<60 -> 60, len>1514 -> 1514.
  - Clear frames_sent and seq.
  - Go to HDR0.
- HDR0 beat: bytes 0-5 = DST_MAC (MSB first), bytes 6-7 = SRC_MAC[47:32].
- HDR1 beat:
  - Bytes 8-11 = SRC_MAC[31:0].
  - Bytes 12-13 = ETHERTYPE (MSB first).
  - Bytes 14-15 = seq[15:8], seq[7:0].
- PAYLOAD beats: the byte at frame offset k (k ≥ 16) = k[7:0].
- Beat count = ceil(len/8). Clamped len ≥ 60, so a frame always has ≥ 8 beats and tlast never falls on HDR0 or HDR1.
- Last beat:
  - tlast = 1.
  - tkeep = 8'hFF if len%8 == 0, else (1<<(len%8))-1.
  - Bytes beyond len are 0.
  - All other beats have tkeep = 8'hFF.
- On the tlast handshake: frames_sent++, seq++. Then:
  - If a stop is pending, or (num_frames ≠ 0 and frames_sent+1 == num_frames): go to IDLE and pulse done.
  - Else if ifg_cycles == 0: go to HDR0.
  - Else: go to IFG, count ifg_cycles cycles with tvalid = 0, then go to HDR0.
- stop latches into stop_pend. It takes effect at the next tlast handshake. In IFG or IDLE-bound states it takes effect immediately: go to IDLE and pulse done.
- busy = (state ≠ IDLE).

## Timing
- All outputs are registered.
- Reset values: tvalid=0, tdata=0, tkeep=0, tlast=0, busy=0, done=0, frames_sent=0, state=IDLE.
- start sampled high at edge N -> tvalid=1 with HDR0 data after edge N; busy is high in the same cycle.
- The beat advances only on tvalid & tready. While tready=0, tdata, tkeep and tlast stay stable.
- With tready held at 1: one beat per cycle. A frame occupies ceil(len/8) cycles, followed by ifg_cycles idle cycles.
- done is asserted in the cycle after the final tlast handshake; busy falls in that same cycle.
- start while busy: ignored. start and stop in the same cycle while idle: start wins; the run ends after frame 1.
- rst mid-frame: all state cleared on the next edge and tvalid drops without tlast. The LMAC must be reset together with this block.
- frames_sent wraps 16'hFFFF -> 0 in continuous mode. seq wraps identically.

## Test plan
- len=60, num=1, ifg=0, tready=1 -> 8 beats on consecutive cycles. Beat 1 bytes 12-15 = 88 B5 00 00. Last tkeep=8'h0F. done one cycle after tlast; frames_sent=1.
- len=61 and len=64 -> 8 beats each, last tkeep 8'h1F and 8'hFF respectively. len=20 -> clamped to 60. len=2000 -> 190 beats, last tkeep 8'h03.
- tready random 50% across a len=100 frame -> data matches the reference model beat-for-beat; no beat dropped or duplicated; outputs stable while stalled.
- num=3, ifg=5 -> three frames with seq 0, 1, 2. Exactly 5 tvalid=0 cycles between frames. done once; frames_sent=3.
- num=0, stop pulsed mid-frame 4 -> frame 4 completes with tlast, then IDLE and done. frames_sent=5 (frames 0-4).
- rst asserted mid-payload -> next cycle all outputs at reset values. A subsequent start produces a clean frame with seq 0.
